// File: rtl/mem_pkg.sv
// Shared definitions for the wait-stated memory port: FSM states and default sizing.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        DONE,
        ERR
    } mem_state_t;

    localparam int DEFAULT_DEPTH       = 256;
    localparam int DEFAULT_WAIT_STATES = 2;
    localparam int DATA_W              = 32;

endpackage

// File: rtl/mem_port_sp_ram.sv
// Single-port synchronous RAM: one write or one registered read per enabled cycle.
module sp_ram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage has no reset; contents survive rst by design.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_port.sv
// Memory port between the control unit and backing RAM: wait states, range check,
// abort during wait, and a 4-phase ready/err handshake.
module mem_port
    import mem_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              oe_data,
    output logic              mem_ready,
    output logic              mem_err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    mem_state_t        state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              op_wr_q;
    logic [AW-1:0]     addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] ram_q;
    logic              req_any, in_range, accept;
    logic              ram_en;

    assign req_any  = mem_rd | mem_wr;
    assign in_range = int'({16'd0, addr}) < DEPTH;
    assign accept   = (state == IDLE) && (mem_rd ^ mem_wr) && in_range;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (req_any) begin
                    if ((mem_rd && mem_wr) || !in_range) begin
                        state_nx = ERR;
                    end else if (WAIT_STATES == 0) begin
                        state_nx = ACCESS;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                // Only the request that started this access can abort it.
                if (op_wr_q ? !mem_wr : !mem_rd) begin
                    state_nx = IDLE;
                end else if (cnt == 4'd0) begin
                    state_nx = ACCESS;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ACCESS: state_nx = DONE;
            DONE, ERR: begin
                if (!req_any) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            op_wr_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                op_wr_q <= mem_wr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= addr[AW-1:0];
            wdata_q <= wdata;
        end
    end

    // Gating with rst keeps a reset coincident with ACCESS from committing a write.
    assign ram_en = (state == ACCESS) && !rst;

    sp_ram #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .AW    (AW)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (op_wr_q),
        .addr (addr_q),
        .wdata(wdata_q),
        .rdata(ram_q)
    );

    assign mem_ready = (state == DONE);
    assign mem_err   = (state == ERR);
    assign oe_data   = (state == DONE) && !op_wr_q;
    assign rdata     = oe_data ? ram_q : '0;

endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port: scoreboard of expected read data, one DUT at
// WAIT_STATES=2 and one at WAIT_STATES=0.
module tb_mem_port;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd = 1'b0, mem_wr = 1'b0;
    logic [15:0] addr = 16'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        oe_data, mem_ready, mem_err;

    logic        rd0 = 1'b0, wr0 = 1'b0;
    logic [15:0] addr0 = 16'd0;
    logic [31:0] rdata0;
    logic        oe0, rdy0, err0;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model [256];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    mem_port #(.DEPTH(256), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr),
        .wdata(wdata), .rdata(rdata), .oe_data(oe_data), .mem_ready(mem_ready),
        .mem_err(mem_err)
    );

    mem_port #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .mem_rd(rd0), .mem_wr(wr0), .addr(addr0),
        .wdata(wdata), .rdata(rdata0), .oe_data(oe0), .mem_ready(rdy0),
        .mem_err(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request (optionally on the current negedge) and hold it until ready/err.
    task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [31:0] d, input bit now, input string tag);
        int          cyc;
        logic        ok;
        logic [31:0] exp;
        ok = (rd ^ wr) && (a < 16'd256);
        if (!now) @(negedge clk);
        mem_rd = rd; mem_wr = wr; addr = a; wdata = d;
        if (ok && rd) exp_q.push_back(model[a[7:0]]);
        cyc = 0;
        while (cyc < 40 && !mem_ready && !mem_err) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, cyc, ok ? 4 : 1);
        check({tag, " ready"}, {31'd0, mem_ready}, {31'd0, ok});
        check({tag, " err"}, {31'd0, mem_err}, {31'd0, !ok});
        check({tag, " oe"}, {31'd0, oe_data}, {31'd0, ok && rd});
        if (ok && rd) begin
            exp = exp_q.pop_front();
            check({tag, " rdata"}, rdata, exp);
        end
        if (ok && wr) model[a[7:0]] = d;
    endtask

    task automatic release_req(input string tag);
        @(negedge clk);
        mem_rd = 1'b0; mem_wr = 1'b0;
        @(negedge clk);
        check({tag, " idle ready"}, {31'd0, mem_ready}, 32'd0);
        check({tag, " idle err"}, {31'd0, mem_err}, 32'd0);
    endtask

    task automatic wait0(output int cyc);
        cyc = 0;
        while (cyc < 40 && !rdy0 && !err0) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int          c;
        logic [15:0] a;
        logic [31:0] d;

        repeat (3) @(negedge clk);
        check("rst ready", {31'd0, mem_ready}, 32'd0);
        check("rst err", {31'd0, mem_err}, 32'd0);
        check("rst oe", {31'd0, oe_data}, 32'd0);
        check("rst rdata", rdata, 32'd0);
        check("rst ready0", {31'd0, rdy0}, 32'd0);
        rst = 1'b0;

        access(0, 1, 16'h0010, 32'hDEADBEEF, 0, "wr10");
        release_req("wr10");
        access(1, 0, 16'h0010, 32'h0, 0, "rd10");
        release_req("rd10");
        access(0, 1, 16'h0005, 32'hA5A50005, 0, "wr5");
        release_req("wr5");
        access(0, 1, 16'h0007, 32'h07070707, 0, "wr7");
        release_req("wr7");
        access(0, 1, 16'h0000, 32'h11111111, 0, "wr0");
        release_req("wr0");

        // Conflicting requests, then out-of-range (0x100 would alias to word 0).
        access(1, 1, 16'h0000, 32'h00000BAD, 0, "both");
        repeat (3) begin
            @(negedge clk);
            check("both err held", {31'd0, mem_err}, 32'd1);
            check("both no ready", {31'd0, mem_ready}, 32'd0);
        end
        release_req("both");
        access(0, 1, 16'h0100, 32'hBADBAD00, 0, "oor");
        @(negedge clk);
        check("oor err held", {31'd0, mem_err}, 32'd1);
        release_req("oor");
        access(1, 0, 16'h0000, 32'h0, 0, "rd0 after err");
        release_req("rd0 after err");

        // Abort a write during WAIT.
        @(negedge clk);
        mem_wr = 1'b1; addr = 16'h0005; wdata = 32'h12345678;
        @(negedge clk);
        mem_wr = 1'b0;
        @(negedge clk);
        check("abort ready", {31'd0, mem_ready}, 32'd0);
        check("abort err", {31'd0, mem_err}, 32'd0);
        access(1, 0, 16'h0005, 32'h0, 0, "rd5 after abort");
        release_req("rd5 after abort");

        // Reset during WAIT of a write.
        @(negedge clk);
        mem_wr = 1'b1; addr = 16'h0007; wdata = 32'hCAFEF00D;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstwait ready", {31'd0, mem_ready}, 32'd0);
        check("rstwait err", {31'd0, mem_err}, 32'd0);
        check("rstwait oe", {31'd0, oe_data}, 32'd0);
        check("rstwait rdata", rdata, 32'd0);
        rst = 1'b0; mem_wr = 1'b0;
        access(1, 0, 16'h0007, 32'h0, 0, "rd7 after rst");
        release_req("rd7 after rst");

        // Reset during DONE of a read.
        access(1, 0, 16'h0010, 32'h0, 0, "rd10 pre-rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstdone ready", {31'd0, mem_ready}, 32'd0);
        check("rstdone oe", {31'd0, oe_data}, 32'd0);
        check("rstdone rdata", rdata, 32'd0);
        rst = 1'b0; mem_rd = 1'b0;
        @(negedge clk);

        // Hold DONE for 5 cycles, then a back-to-back request.
        access(1, 0, 16'h0005, 32'h0, 0, "hold");
        repeat (5) begin
            @(negedge clk);
            check("hold ready", {31'd0, mem_ready}, 32'd1);
            check("hold rdata", rdata, model[5]);
        end
        mem_rd = 1'b0;
        @(negedge clk);
        check("hold idle", {31'd0, mem_ready}, 32'd0);
        access(1, 0, 16'h0007, 32'h0, 1, "b2b");
        release_req("b2b");

        for (int i = 0; i < 6; i++) begin
            a = 16'(32 + i * 3);
            d = $urandom;
            access(0, 1, a, d, 0, "rnd wr");
            release_req("rnd wr");
        end
        for (int i = 5; i >= 0; i--) begin
            a = 16'(32 + i * 3);
            access(1, 0, a, 32'h0, 0, "rnd rd");
            release_req("rnd rd");
        end

        // Zero wait states.
        @(negedge clk);
        wr0 = 1'b1; addr0 = 16'h0003; wdata = 32'h0BADF00D;
        wait0(c);
        check("ws0 wr latency", c, 2);
        check("ws0 wr oe", {31'd0, oe0}, 32'd0);
        wr0 = 1'b0;
        repeat (2) @(negedge clk);
        rd0 = 1'b1;
        wait0(c);
        check("ws0 rd latency", c, 2);
        check("ws0 rd oe", {31'd0, oe0}, 32'd1);
        check("ws0 rd rdata", rdata0, 32'h0BADF00D);
        rd0 = 1'b0;
        repeat (2) @(negedge clk);
        check("ws0 idle", {31'd0, rdy0}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
